// File: rtl/or_chk_pkg.sv
// Shared types and constants for the OR-datapath response checker.
package or_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSettle,
    StCheck,
    StDone
  } or_chk_state_t;

  localparam int unsigned OR_CHK_SETTLE_MAX = 15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/or_resp_checker.sv
// Response checker for a two-input OR DUT: accepts a vector, waits SETTLE_CYC, compares a1_obs.
// Optional first-failure capture (fail_idx/fail_vec) is enabled by OR_CHK_FIRST_FAIL_EN.
module or_resp_checker
  import or_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic             i1,
  input  logic             i2,
  output logic             vec_ready,
  input  logic             a1_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef OR_CHK_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] fail_idx,
  output logic [2:0]       fail_vec
`endif
);

  // Out-of-range settle values are clamped into the 4-bit counter's 1..15 window.
  localparam int unsigned SettleEff = (SETTLE_CYC > OR_CHK_SETTLE_MAX) ? OR_CHK_SETTLE_MAX :
                                      (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam logic [3:0]  SettleLoad = 4'(SettleEff - 1);

  or_chk_state_t state_d, state_q;
  logic [3:0]    settle_d, settle_q;
  logic          exp_q, last_q;
  logic          accept, run_clr, chk, mism;

  assign accept  = (state_q == StRun) && vec_valid;
  assign run_clr = start && ((state_q == StIdle) || (state_q == StDone));
  assign chk     = (state_q == StCheck);
  assign mism    = chk && (a1_obs != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (vec_valid) state_d = StSettle;
      StSettle:       if (settle_q == 4'd0) state_d = StCheck;
      StCheck:        state_d = last_q ? StDone : StRun;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_ready = (state_q == StRun);
    busy      = (state_q == StRun) || (state_q == StSettle) || (state_q == StCheck);
    done      = (state_q == StDone);
    pass      = done && (err_cnt == '0);
  end

  always_comb begin
    settle_d = settle_q;
    if (accept) begin
      settle_d = SettleLoad;
    end else if ((state_q == StSettle) && (settle_q != 4'd0)) begin
      settle_d = settle_q - 4'd1;
    end
  end

  // Vector fields are captured only on the handshake so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 4'd0;
      exp_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      if (accept) begin
        exp_q  <= i1 | i2;
        last_q <= vec_last;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_clr),
    .inc   (chk),
    .cnt   (vec_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_clr),
    .inc   (mism),
    .cnt   (err_cnt)
  );

`ifdef OR_CHK_FIRST_FAIL_EN
  logic             i1_q, i2_q;
  logic [CNT_W-1:0] fail_idx_q;
  logic [2:0]       fail_vec_q;

  // err_cnt saturates but never returns to zero, so zero marks "no failure yet" this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q       <= 1'b0;
      i2_q       <= 1'b0;
      fail_idx_q <= '0;
      fail_vec_q <= 3'b000;
    end else begin
      if (accept) begin
        i1_q <= i1;
        i2_q <= i2;
      end
      if (run_clr) begin
        fail_idx_q <= '0;
        fail_vec_q <= 3'b000;
      end else if (mism && (err_cnt == '0)) begin
        fail_idx_q <= vec_cnt;
        fail_vec_q <= {i1_q, i2_q, a1_obs};
      end
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_or_resp_checker.sv
// Directed + randomized bench for or_resp_checker; two instances (CNT_W=8 and CNT_W=2) in lockstep.
module tb_or_resp_checker;

  localparam int unsigned S  = 3;
  localparam int unsigned WA = 8;
  localparam int unsigned WB = 2;

  logic clk = 1'b0;
  logic rst_n, start, vec_valid, vec_last, i1, i2, a1_obs;
  logic ready_a, busy_a, done_a, pass_a;
  logic ready_b, busy_b, done_b, pass_b;
  logic [WA-1:0] vc_a, ec_a;
  logic [WB-1:0] vc_b, ec_b;
`ifdef OR_CHK_FIRST_FAIL_EN
  logic [WA-1:0] fi_a;
  logic [WB-1:0] fi_b;
  logic [2:0]    fv_a, fv_b;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_vec, m_err, m_fidx;
  logic [2:0] m_fvec;
  bit   m_seen;

  always #5 clk = ~clk;

  or_resp_checker #(.SETTLE_CYC(S), .CNT_W(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .i1(i1), .i2(i2), .vec_ready(ready_a), .a1_obs(a1_obs), .busy(busy_a), .done(done_a),
    .pass(pass_a), .vec_cnt(vc_a), .err_cnt(ec_a)
`ifdef OR_CHK_FIRST_FAIL_EN
    , .fail_idx(fi_a), .fail_vec(fv_a)
`endif
  );

  or_resp_checker #(.SETTLE_CYC(S), .CNT_W(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .i1(i1), .i2(i2), .vec_ready(ready_b), .a1_obs(a1_obs), .busy(busy_b), .done(done_b),
    .pass(pass_b), .vec_cnt(vc_b), .err_cnt(ec_b)
`ifdef OR_CHK_FIRST_FAIL_EN
    , .fail_idx(fi_b), .fail_vec(fv_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input bit fin);
    check({tag, ".vec_a"},  32'(vc_a),   32'(sat(m_vec, WA)));
    check({tag, ".err_a"},  32'(ec_a),   32'(sat(m_err, WA)));
    check({tag, ".vec_b"},  32'(vc_b),   32'(sat(m_vec, WB)));
    check({tag, ".err_b"},  32'(ec_b),   32'(sat(m_err, WB)));
    check({tag, ".done_a"}, 32'(done_a), 32'(fin));
    check({tag, ".pass_a"}, 32'(pass_a), 32'(fin && (m_err == 0)));
    check({tag, ".pass_b"}, 32'(pass_b), 32'(fin && (m_err == 0)));
`ifdef OR_CHK_FIRST_FAIL_EN
    check({tag, ".fidx_a"}, 32'(fi_a), m_seen ? 32'(sat(m_fidx, WA)) : 32'd0);
    check({tag, ".fidx_b"}, 32'(fi_b), m_seen ? 32'(sat(m_fidx, WB)) : 32'd0);
    check({tag, ".fvec_a"}, 32'(fv_a), 32'(m_fvec));
    check({tag, ".fvec_b"}, 32'(fv_b), 32'(m_fvec));
`endif
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_vec = 0; m_err = 0; m_fidx = 0; m_fvec = 3'b000; m_seen = 1'b0;
    check("start.ready", 32'(ready_a), 32'd1);
    check("start.busy",  32'(busy_a),  32'd1);
    check("start.clr",   32'(vc_a),    32'd0);
  endtask

  // obs is the correct-or-not final DUT output, applied d cycles after the handshake;
  // before that the opposite value is driven. The checker samples S+1 edges after handshake.
  task automatic send(input logic a, input logic b, input logic last, input logic obs,
                      input int d);
    int   k;
    logic sampled;
    k = 0;
    i1 = a; i2 = b; vec_last = last; vec_valid = 1'b1;
    a1_obs = (d == 0) ? obs : ~obs;
    while (!ready_a && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      check("handshake_timeout", 32'd0, 32'd1);
      vec_valid = 1'b0;
      return;
    end
    tick();
    vec_valid = 1'b0;
    i1 = 1'($urandom); i2 = 1'($urandom); vec_last = 1'($urandom);
    check("settle.ready", 32'(ready_a), 32'd0);
    for (int e = 0; e <= int'(S); e++) begin
      if (e == d) a1_obs = obs;
      tick();
    end
    sampled = (d <= int'(S)) ? obs : ~obs;
    if (sampled != (a | b)) begin
      if (!m_seen) begin
        m_seen = 1'b1;
        m_fidx = m_vec;
        m_fvec = {a, b, sampled};
      end
      m_err++;
    end
    m_vec++;
    check_counts("vec", last);
    check("after.ready", 32'(ready_a), 32'(!last));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    i1 = 1'b0; i2 = 1'b0; a1_obs = 1'b0;
    m_vec = 0; m_err = 0; m_fidx = 0; m_fvec = 3'b000; m_seen = 1'b0;
    tick();
    tick();
    check("reset.ready", 32'(ready_a), 32'd0);
    check("reset.busy",  32'(busy_a),  32'd0);
    check("reset.done",  32'(done_a),  32'd0);
    check("reset.pass",  32'(pass_a),  32'd0);
    check("reset.cnts",  32'({vc_a, ec_a}), 32'd0);
    rst_n = 1'b1;
    tick();

    // All-good run
    start_run();
    send(1'b0, 1'b0, 1'b0, 1'b0, 0);
    send(1'b0, 1'b1, 1'b0, 1'b1, 0);
    send(1'b1, 1'b0, 1'b0, 1'b1, 0);
    send(1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("good.vec_cnt", 32'(vc_a), 32'd4);
    check("good.pass",    32'(pass_a), 32'd1);
    check("good.busy",    32'(busy_a), 32'd0);

    // Stuck-at-0 DUT
    start_run();
    send(1'b0, 1'b0, 1'b0, 1'b0, 0);
    send(1'b0, 1'b1, 1'b0, 1'b0, 0);
    send(1'b1, 1'b0, 1'b0, 1'b0, 0);
    send(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("sa0.err_cnt", 32'(ec_a), 32'd3);
    check("sa0.pass",    32'(pass_a), 32'd0);
`ifdef OR_CHK_FIRST_FAIL_EN
    check("sa0.fail_idx", 32'(fi_a), 32'd1);
    check("sa0.fail_vec", 32'(fv_a), 32'b010);
`endif

    // Settle timing: exactly S cycles late is fine, S+1 is an error
    start_run();
    send(1'b0, 1'b1, 1'b0, 1'b1, 3);
    send(1'b1, 1'b1, 1'b1, 1'b1, 4);
    check("settle.err_cnt", 32'(ec_a), 32'd1);

    // Saturation on the narrow instance
    start_run();
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, logic'(i == 5), 1'b0, 0);
    check("sat.err_b", 32'(ec_b), 32'd3);
    check("sat.vec_b", 32'(vc_b), 32'd3);
    check("sat.err_a", 32'(ec_a), 32'd6);

    // Randomized run
    start_run();
    for (int i = 0; i < 10; i++) begin
      logic a, b, o;
      int   d;
      a = 1'($urandom); b = 1'($urandom);
      o = ($urandom_range(0, 3) == 0) ? ~(a | b) : (a | b);
      d = int'($urandom_range(0, 4));
      send(a, b, logic'(i == 9), o, d);
    end

    // Mid-run disturbance: start/vec_valid during SETTLE ignored, then async reset
    start_run();
    send(1'b1, 1'b0, 1'b0, 1'b1, 0);
    i1 = 1'b0; i2 = 1'b1; vec_last = 1'b0; vec_valid = 1'b1; a1_obs = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("dist.ready", 32'(ready_a), 32'd0);
    check("dist.vec",   32'(vc_a),    32'd1);
    check("dist.busy",  32'(busy_a),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.ready", 32'(ready_a), 32'd0);
    check("rst.busy",  32'(busy_a),  32'd0);
    check("rst.done",  32'(done_a),  32'd0);
    check("rst.cnts",  32'({vc_a, ec_a, vc_b, ec_b}), 32'd0);
    vec_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle.ready", 32'(ready_a), 32'd0);
    start_run();
    send(1'b1, 1'b1, 1'b0, 1'b1, 0);
    send(1'b0, 1'b0, 1'b1, 1'b0, 1);
    check("fresh.pass", 32'(pass_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
